// File: rtl/spart_rx_if.sv
// Receive-side bundle of the mini-spart UART: baud tick, serial line,
// bus acknowledge strobe and the received byte with its status flags.
interface spart_rx_if;
    logic       en;
    logic       RxD;
    logic       clr_rda;
    logic [7:0] data;
    logic       rda;
    logic       ferr;

    modport master (
        output en, RxD, clr_rda,
        input  data, rda, ferr
    );

    modport slave (
        input  en, RxD, clr_rda,
        output data, rda, ferr
    );
endinterface

// File: rtl/spart_rx.sv
// 8N1 UART receiver with 16x oversampling on the shared baud tick.
// Define SPART_RX_FERR_EN to check the stop bit and raise a sticky ferr.
module spart_rx (
    input logic       clk,
    input logic       rst,
    spart_rx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] tick, tick_nxt;
    logic [3:0] bit_cnt, bit_nxt;
    logic [7:0] sh, sh_nxt;
    logic       sync1, rx_s;
    logic       stop_tick;
    logic       load;
    logic [7:0] data_r;
    logic       rda_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.RxD;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= 4'd0;
            bit_cnt <= 4'd0;
            sh      <= 8'h00;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_nxt;
            sh      <= sh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        stop_tick = 1'b0;
        if (bus.en) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = 4'd0;
                    end
                end
                // Eight ticks after the falling edge lands on the bit midpoint.
                START: begin
                    if (tick == 4'd7) begin
                        tick_nxt  = 4'd0;
                        bit_nxt   = 4'd0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        tick_nxt = tick + 4'd1;
                    end
                end
                DATA: begin
                    if (tick == 4'd15) begin
                        tick_nxt = 4'd0;
                        sh_nxt   = {rx_s, sh[7:1]};
                        bit_nxt  = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7)
                            state_nxt = STOP;
                    end else begin
                        tick_nxt = tick + 4'd1;
                    end
                end
                STOP: begin
                    if (tick == 4'd15) begin
                        tick_nxt  = 4'd0;
                        stop_tick = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef SPART_RX_FERR_EN
    logic ferr_set;
    logic ferr_r;

    assign load     = stop_tick && rx_s;
    assign ferr_set = stop_tick && !rx_s;

    // A set in the same cycle as the acknowledge must not be lost.
    always_ff @(posedge clk) begin
        if (rst)
            ferr_r <= 1'b0;
        else if (ferr_set)
            ferr_r <= 1'b1;
        else if (bus.clr_rda)
            ferr_r <= 1'b0;
    end

    assign bus.ferr = ferr_r;
`else
    assign load     = stop_tick;
    assign bus.ferr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= 8'h00;
            rda_r  <= 1'b0;
        end else if (load) begin
            data_r <= sh;
            rda_r  <= 1'b1;
        end else if (bus.clr_rda) begin
            rda_r <= 1'b0;
        end
    end

    assign bus.data = data_r;
    assign bus.rda  = rda_r;
endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: en every 4th clk, 16 ticks per serial bit,
// outputs checked on the falling edge.
module tb_spart_rx;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    spart_rx_if bus ();

    spart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One baud tick: en high for one cycle, then three idle cycles.
    task automatic do_tick();
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        bus.RxD = 1'b1;
        repeat (n) do_tick();
    endtask

    // Start bit, data bits, then the stop bit up to the tick before sampling.
    task automatic send_upto(input logic [7:0] b, input logic stopv);
        bus.RxD = 1'b0;
        repeat (16) do_tick();
        for (int i = 0; i < 8; i++) begin
            bus.RxD = b[i];
            repeat (16) do_tick();
        end
        bus.RxD = stopv;
        repeat (9) do_tick();
    endtask

    // The stop-sample tick; outputs are checked right after the load edge.
    task automatic sample_tick(input logic clr);
        bus.en      = 1'b1;
        bus.clr_rda = clr;
        @(negedge clk);
        bus.en      = 1'b0;
        bus.clr_rda = 1'b0;
    endtask

    // Rest of the stop-bit period, optionally acknowledging the byte.
    task automatic tail(input logic clr);
        bus.RxD     = 1'b1;
        bus.clr_rda = clr;
        @(negedge clk);
        bus.clr_rda = 1'b0;
        repeat (2) @(negedge clk);
        repeat (6) do_tick();
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.RxD     = 1'b1;
        bus.clr_rda = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_data", bus.data, 8'h00);
        chk("reset_rda", {7'd0, bus.rda}, 8'h00);
        chk("reset_ferr", {7'd0, bus.ferr}, 8'h00);
        idle_ticks(4);

        send_upto(8'h55, 1'b1);
        chk("b55_rda_pre", {7'd0, bus.rda}, 8'h00);
        sample_tick(1'b0);
        chk("b55_rda", {7'd0, bus.rda}, 8'h01);
        chk("b55_data", bus.data, 8'h55);
        tail(1'b0);
        bus.clr_rda = 1'b1;
        @(negedge clk);
        bus.clr_rda = 1'b0;
        chk("b55_clr_rda", {7'd0, bus.rda}, 8'h00);
        chk("b55_clr_data", bus.data, 8'h55);

        send_upto(8'hA3, 1'b1);
        sample_tick(1'b0);
        chk("bb_a3_data", bus.data, 8'hA3);
        chk("bb_a3_rda", {7'd0, bus.rda}, 8'h01);
        tail(1'b1);
        chk("bb_a3_clr", {7'd0, bus.rda}, 8'h00);
        send_upto(8'h0F, 1'b1);
        sample_tick(1'b0);
        chk("bb_0f_data", bus.data, 8'h0F);
        chk("bb_0f_rda", {7'd0, bus.rda}, 8'h01);
        tail(1'b1);

        bus.RxD = 1'b0;
        repeat (4) do_tick();
        idle_ticks(20);
        chk("glitch_rda", {7'd0, bus.rda}, 8'h00);
        chk("glitch_data", bus.data, 8'h0F);
        send_upto(8'h3C, 1'b1);
        sample_tick(1'b0);
        chk("post_glitch_data", bus.data, 8'h3C);
        chk("post_glitch_rda", {7'd0, bus.rda}, 8'h01);
        tail(1'b1);

        send_upto(8'h11, 1'b1);
        sample_tick(1'b0);
        chk("b11_data", bus.data, 8'h11);
        tail(1'b0);
        send_upto(8'h22, 1'b1);
        sample_tick(1'b1);
        chk("ldclr_rda", {7'd0, bus.rda}, 8'h01);
        chk("ldclr_data", bus.data, 8'h22);
        tail(1'b1);
        chk("ldclr_after", {7'd0, bus.rda}, 8'h00);

        send_upto(8'h7E, 1'b0);
        sample_tick(1'b0);
`ifdef SPART_RX_FERR_EN
        chk("ferr_set", {7'd0, bus.ferr}, 8'h01);
        chk("ferr_rda", {7'd0, bus.rda}, 8'h00);
        chk("ferr_data", bus.data, 8'h22);
        tail(1'b1);
        chk("ferr_clr", {7'd0, bus.ferr}, 8'h00);
`else
        chk("nochk_data", bus.data, 8'h7E);
        chk("nochk_rda", {7'd0, bus.rda}, 8'h01);
        chk("nochk_ferr", {7'd0, bus.ferr}, 8'h00);
        tail(1'b1);
        chk("nochk_clr", {7'd0, bus.rda}, 8'h00);
`endif
        idle_ticks(4);

        send_upto(8'h5A, 1'b1);
        sample_tick(1'b0);
        chk("b5a_rda", {7'd0, bus.rda}, 8'h01);
        tail(1'b0);
        bus.RxD = 1'b0;
        repeat (16) do_tick();
        bus.RxD = 1'b1;
        repeat (64) do_tick();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_data", bus.data, 8'h00);
        chk("mid_rst_rda", {7'd0, bus.rda}, 8'h00);
        chk("mid_rst_ferr", {7'd0, bus.ferr}, 8'h00);
        idle_ticks(20);
        chk("mid_rst_idle", {7'd0, bus.rda}, 8'h00);
        send_upto(8'h81, 1'b1);
        sample_tick(1'b0);
        chk("b81_data", bus.data, 8'h81);
        chk("b81_rda", {7'd0, bus.rda}, 8'h01);
        tail(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
